esc_multi_ramp: RTL and testbench

- Parametrised N-channel motor drive stage. Sits between the flight controller's per-motor speed outputs (frnt/bck/lft/rght_spd) and the ESC pins.
- Per channel: slew-limits commanded speed once per PWM frame, then generates an ESC pulse of width OFFSET + SCALE*speed.
- Adds arm/off control and a controlled emergency-land ramp-down. The previous fixed 4-channel ESC interface had neither.

---
 rtl/esc_multi_ramp.sv | 137 +++++++++++++
 tb/tb_esc_multi_ramp.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/esc_multi_ramp.sv
// esc_multi_ramp: N-channel ESC drive stage. Per channel the commanded speed is
// slew-limited once per PWM frame and turned into a pulse of OFFSET + SCALE*speed
// clocks. Arm/off control and a frame-stepped emergency-land ramp-down are included.
// Ports: clk, rst_n (async, active low); spd_tgt (packed per channel); arm/emer_land
// pulses; mtrs_off level; pwm per channel; cur_spd (slewed speed); frame_strt;
// settled; landing; armed.
module esc_multi_ramp #(
  parameter int NUM_CH    = 4,
  parameter int SPD_W     = 11,
  parameter int PERIOD_W  = 20,
  parameter int OFFSET    = 6250,
  parameter int SCALE     = 3,
  parameter int STEP      = 16,
  parameter int EMER_STEP = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*SPD_W-1:0]   spd_tgt,
  input  logic                      arm,
  input  logic                      emer_land,
  input  logic                      mtrs_off,
  output logic [NUM_CH-1:0]         pwm,
  output logic [NUM_CH*SPD_W-1:0]   cur_spd,
  output logic                      frame_strt,
  output logic                      settled,
  output logic                      landing,
  output logic                      armed
);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_LAND} state_t;

  localparam logic [SPD_W:0]    STEP_X  = (SPD_W+1)'(STEP);
  localparam logic [SPD_W:0]    EMER_X  = (SPD_W+1)'(EMER_STEP);
  localparam logic [PERIOD_W-1:0] OFF_X = PERIOD_W'(OFFSET);
  localparam logic [PERIOD_W-1:0] SCL_X = PERIOD_W'(SCALE);

  state_t state, state_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt;
  logic frame_edge;

  logic [NUM_CH-1:0][SPD_W-1:0]    tgt, cur, cur_nxt, slewed;
  logic [NUM_CH-1:0][PERIOD_W-1:0] width, width_nxt, width_calc;
  logic [NUM_CH-1:0]               pwm_nxt;
  logic                            all_zero;
  logic                            active_nxt;

  assign tgt        = spd_tgt;
  assign cur_spd    = cur;
  assign cnt_nxt    = cnt + 1'b1;
  // The frame edge is the clock edge on which cnt wraps back to zero.
  assign frame_edge = (cnt == {PERIOD_W{1'b1}});

  // Per-channel slew result, evaluated against the state held during the
  // frame that is ending. Compares are done one bit wider so nothing wraps.
  always_comb begin
    all_zero   = 1'b1;
    slewed     = '0;
    width_calc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      slewed[i] = '0;
      case (state)
        S_RUN: begin
          if (tgt[i] > cur[i]) begin
            if ({1'b0, cur[i]} + STEP_X >= {1'b0, tgt[i]}) slewed[i] = tgt[i];
            else                                            slewed[i] = cur[i] + STEP_X[SPD_W-1:0];
          end else if (tgt[i] < cur[i]) begin
            if ({1'b0, tgt[i]} + STEP_X >= {1'b0, cur[i]}) slewed[i] = tgt[i];
            else                                            slewed[i] = cur[i] - STEP_X[SPD_W-1:0];
          end else begin
            slewed[i] = cur[i];
          end
        end
        S_LAND: begin
          if ({1'b0, cur[i]} <= EMER_X) slewed[i] = '0;
          else                          slewed[i] = cur[i] - EMER_X[SPD_W-1:0];
        end
        default: slewed[i] = '0;
      endcase
      if (slewed[i] != '0) all_zero = 1'b0;
      width_calc[i] = OFF_X + SCL_X * {{(PERIOD_W-SPD_W){1'b0}}, slewed[i]};
    end
  end

  // State transitions: mtrs_off dominates, then emer_land, then arm.
  always_comb begin
    state_nxt = state;
    if (mtrs_off) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:   if (arm) state_nxt = S_RUN;
        S_RUN:   if (emer_land) state_nxt = S_LAND;
        S_LAND:  if (frame_edge && all_zero) state_nxt = S_OFF;
        default: state_nxt = S_OFF;
      endcase
    end
  end

  always_comb begin
    cur_nxt    = cur;
    width_nxt  = width;
    pwm_nxt    = '0;
    active_nxt = (state_nxt != S_OFF);
    if (mtrs_off)        cur_nxt = '0;
    else if (frame_edge) cur_nxt = slewed;
    if (frame_edge) width_nxt = width_calc;
    // A pulse may only begin at frame start; after that it is held until
    // cnt reaches the width. Arming mid-frame therefore waits a full frame.
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_nxt[i] = active_nxt && (frame_edge || pwm[i]) && (cnt_nxt < width_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      cnt        <= '0;
      cur        <= '0;
      width      <= {NUM_CH{OFF_X}};
      pwm        <= '0;
      frame_strt <= 1'b0;
      settled    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cur        <= cur_nxt;
      width      <= width_nxt;
      pwm        <= pwm_nxt;
      frame_strt <= frame_edge;
      settled    <= (state == S_RUN) && (cur == tgt);
    end
  end

  assign armed   = (state != S_OFF);
  assign landing = (state == S_LAND);

endmodule

// File: tb/tb_esc_multi_ramp.sv
module tb_esc_multi_ramp;
  localparam int NC = 4;
  localparam int SW = 8;
  localparam int PW = 11;
  localparam int FR = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n = 1'b0;
  logic [NC*SW-1:0]    spd_tgt = '0;
  logic                arm = 1'b0;
  logic                emer_land = 1'b0;
  logic                mtrs_off = 1'b0;
  logic [NC-1:0]       pwm;
  logic [NC*SW-1:0]    cur_spd;
  logic                frame_strt, settled, landing, armed;

  esc_multi_ramp #(
    .NUM_CH(NC), .SPD_W(SW), .PERIOD_W(PW), .OFFSET(100), .SCALE(3),
    .STEP(16), .EMER_STEP(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spd_tgt(spd_tgt), .arm(arm), .emer_land(emer_land),
    .mtrs_off(mtrs_off), .pwm(pwm), .cur_spd(cur_spd), .frame_strt(frame_strt),
    .settled(settled), .landing(landing), .armed(armed)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0]      spd;
    logic [3:0][15:0] wid;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected frame: speeds as given, pulse width 100 + 3*speed when driving, else 0.
  function automatic exp_t mk(input logic [31:0] s, input bit on);
    exp_t e;
    e.spd = s;
    for (int c = 0; c < NC; c++) e.wid[c] = on ? 16'(100 + 3 * int'(s[c*SW +: SW])) : 16'd0;
    return e;
  endfunction

  function automatic exp_t mkw(input logic [31:0] s, input logic [15:0] w);
    exp_t e;
    e.spd = s;
    for (int c = 0; c < NC; c++) e.wid[c] = w;
    return e;
  endfunction

  function automatic logic [7:0] slew(input logic [7:0] c, input logic [7:0] t);
    int ci, ti;
    ci = int'(c);
    ti = int'(t);
    if (ti > ci)      return (ci + 16 > ti) ? t : 8'(ci + 16);
    else if (ti < ci) return (ci - 16 < ti) ? t : 8'(ci - 16);
    else              return c;
  endfunction

  task automatic sync_frame(input string tag);
    int n;
    n = 0;
    while (!frame_strt && n < FR + 4) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " sync"}, 64'(frame_strt), 64'd1);
  endtask

  // Called at the negedge of a frame-start cycle. Drives the optional
  // {mtrs_off, emer_land, arm} pulse for the first cycle, measures the frame,
  // and compares against the oldest scoreboard entry.
  task automatic do_frame(input string tag, input logic [2:0] pulse);
    exp_t        e;
    logic [31:0] s;
    int          hi [NC];
    s = cur_spd;
    {mtrs_off, emer_land, arm} = pulse;
    for (int c = 0; c < NC; c++) hi[c] = 0;
    for (int k = 0; k < FR; k++) begin
      for (int c = 0; c < NC; c++) if (pwm[c]) hi[c]++;
      @(negedge clk);
      {mtrs_off, emer_land, arm} = 3'b000;
    end
    chk({tag, " sb_has_entry"}, 64'(sb.size() > 0), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, " spd"}, 64'(s), 64'(e.spd));
    for (int c = 0; c < NC; c++)
      chk($sformatf("%s width%0d", tag, c), 64'(hi[c]), 64'(e.wid[c]));
  endtask

  initial begin
    logic [31:0] m, tgt3;
    int n;

    // Reset values
    @(negedge clk);
    chk("rst pwm", 64'(pwm), 64'd0);
    chk("rst cur", 64'(cur_spd), 64'd0);
    chk("rst frame_strt", 64'(frame_strt), 64'd0);
    chk("rst settled", 64'(settled), 64'd0);
    chk("rst landing", 64'(landing), 64'd0);
    chk("rst armed", 64'(armed), 64'd0);

    // 1: arm mid-frame, ramp to 0x40
    rst_n = 1'b1;
    spd_tgt = {4{8'h40}};
    repeat (3) @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("arm armed", 64'(armed), 64'd1);
    chk("arm settled", 64'(settled), 64'd0);
    repeat (20) @(negedge clk);
    chk("arm no partial pulse", 64'(pwm), 64'd0);
    sync_frame("ramp");
    sb.push_back(mk({4{8'h10}}, 1'b1));
    sb.push_back(mk({4{8'h20}}, 1'b1));
    sb.push_back(mk({4{8'h30}}, 1'b1));
    sb.push_back(mk({4{8'h40}}, 1'b1));
    for (int f = 0; f < 4; f++) do_frame($sformatf("ramp%0d", f), 3'b000);
    chk("ramp settled", 64'(settled), 64'd1);

    // 2: small decrease clamps to target; mid-frame change waits for edge
    spd_tgt = {4{8'h38}};
    sb.push_back(mk({4{8'h40}}, 1'b1));
    sb.push_back(mk({4{8'h38}}, 1'b1));
    do_frame("dec_hold", 3'b000);
    do_frame("dec_clamp", 3'b000);

    // 3: ramp to mixed speeds, then emergency land
    tgt3 = {8'h00, 8'h40, 8'h80, 8'hC8};
    spd_tgt = tgt3;
    m = {4{8'h38}};
    sb.push_back(mk(m, 1'b1));
    for (int f = 0; f < 9; f++) begin
      for (int c = 0; c < NC; c++) m[c*SW +: SW] = slew(m[c*SW +: SW], tgt3[c*SW +: SW]);
      sb.push_back(mk(m, 1'b1));
    end
    for (int f = 0; f < 10; f++) do_frame($sformatf("mix%0d", f), 3'b000);
    chk("mix reached", 64'(cur_spd), 64'(tgt3));
    sb.push_back(mk(tgt3, 1'b1));
    do_frame("land0", 3'b010);
    chk("land landing", 64'(landing), 64'd1);
    sb.push_back(mk(32'h0000_4088, 1'b1));
    sb.push_back(mk(32'h0000_0048, 1'b1));
    sb.push_back(mk(32'h0000_0008, 1'b1));
    do_frame("land1", 3'b000);
    do_frame("land2", 3'b000);
    do_frame("land3", 3'b000);
    chk("land done armed", 64'(armed), 64'd0);
    chk("land done landing", 64'(landing), 64'd0);
    sb.push_back(mk(32'h0, 1'b0));
    do_frame("land4", 3'b000);

    // 4: mtrs_off mid-pulse, arm blocked while off, re-arm
    spd_tgt = {4{8'h20}};
    sb.push_back(mk(32'h0, 1'b0));
    do_frame("arm_at_cnt0", 3'b001);
    repeat (50) @(negedge clk);
    chk("off pre pwm", 64'(pwm), 64'hF);
    mtrs_off = 1'b1;
    @(negedge clk);
    chk("off pwm", 64'(pwm), 64'd0);
    chk("off cur", 64'(cur_spd), 64'd0);
    chk("off armed", 64'(armed), 64'd0);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
    chk("off arm blocked", 64'(armed), 64'd0);
    mtrs_off = 1'b0;
    spd_tgt = '0;
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("rearm armed", 64'(armed), 64'd1);
    chk("rearm pwm", 64'(pwm), 64'd0);
    sync_frame("rearm");
    sb.push_back(mkw(32'h0, 16'd100));
    do_frame("rearm", 3'b000);

    // 5: all three controls together, then emer_land in OFF
    sb.push_back(mkw(32'h0, 16'd1));
    do_frame("all3", 3'b111);
    chk("all3 armed", 64'(armed), 64'd0);
    sb.push_back(mk(32'h0, 1'b0));
    do_frame("emer_in_off", 3'b010);
    chk("emer_in_off armed", 64'(armed), 64'd0);
    chk("emer_in_off landing", 64'(landing), 64'd0);

    // 6: async reset during LAND
    spd_tgt = {4{8'h40}};
    sb.push_back(mk(32'h0, 1'b0));
    do_frame("arm6", 3'b001);
    emer_land = 1'b1;
    @(negedge clk);
    emer_land = 1'b0;
    repeat (40) @(negedge clk);
    chk("r6 landing", 64'(landing), 64'd1);
    chk("r6 pwm", 64'(pwm), 64'hF);
    chk("r6 cur", 64'(cur_spd), 64'({4{8'h10}}));
    #2 rst_n = 1'b0;
    #1;
    chk("async pwm", 64'(pwm), 64'd0);
    chk("async cur", 64'(cur_spd), 64'd0);
    chk("async landing", 64'(landing), 64'd0);
    chk("async armed", 64'(armed), 64'd0);
    chk("async settled", 64'(settled), 64'd0);
    chk("async frame_strt", 64'(frame_strt), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strt && n < 3000);
    chk("post rst first frame", 64'(n), 64'd2048);
    chk("post rst armed", 64'(armed), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
